// File: rtl/config_chain_loader_if.sv
`default_nettype none
// ============================================================================
// config_chain_loader_if : word handshake, serial chain and readback bundle
// Revision : 1.0
// ============================================================================
interface config_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              START;
  logic [WORD_W-1:0] DIN;
  logic              DIN_VALID;
  logic              DIN_READY;
  logic              SOUT;
  logic              CE;
  logic              SIN_RET;
  logic [WORD_W-1:0] RB_DATA;
  logic              RB_VALID;
  logic              BUSY;
  logic              DONE;

  modport master (
    output START, DIN, DIN_VALID, SIN_RET,
    input  DIN_READY, SOUT, CE, RB_DATA, RB_VALID, BUSY, DONE
  );

  modport slave (
    input  START, DIN, DIN_VALID, SIN_RET,
    output DIN_READY, SOUT, CE, RB_DATA, RB_VALID, BUSY, DONE
  );
endinterface
`default_nettype wire

// File: rtl/config_chain_loader.sv
`default_nettype none
// ============================================================================
// config_chain_loader : shifts configuration words LSB-first into the fabric
//                       scan chain and reads the previous contents back.
// Revision : 1.0
// ============================================================================
module config_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 22,
  parameter int CNT_W     = 16
) (
  input  wire logic           CLK,
  input  wire logic           RST_N,
  config_chain_loader_if.slave bus
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SHIFT  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            state_q,    state_d;
  logic [WORD_W-1:0] shreg_q,    shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  logic [WORD_W-1:0] rb_q,       rb_d;
  logic              rb_valid_q, rb_valid_d;

  logic w_last_bit;
  logic w_last_idx;

  assign w_last_bit = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
  assign w_last_idx = (idx_q == IDX_W'(WORD_W - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      rb_q       <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      idx_q      <= idx_d;
      rb_q       <= rb_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    idx_d      = idx_q;
    rb_d       = rb_q;
    rb_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          rb_d      = '0;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        if (bus.DIN_VALID) begin
          shreg_d = bus.DIN;
          idx_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        shreg_d = shreg_q >> 1;
        // Clearing at each word start keeps unfilled bits of a partial last word at 0
        if (idx_q == '0) begin
          rb_d = '0;
        end
        rb_d[idx_q] = bus.SIN_RET;
        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        idx_d       = w_last_idx ? '0 : (idx_q + IDX_W'(1));
        if (w_last_bit) begin
          state_d    = S_FINISH;
          rb_valid_d = 1'b1;
        end else if (w_last_idx) begin
          state_d    = S_LOAD;
          rb_valid_d = 1'b1;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Chain-facing outputs decode state only, so reset kills CE asynchronously
  assign bus.DIN_READY = (state_q == S_LOAD);
  assign bus.CE        = (state_q == S_SHIFT);
  assign bus.SOUT      = (state_q == S_SHIFT) && shreg_q[0];
  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.DONE      = (state_q == S_FINISH);
  assign bus.RB_DATA   = rb_q;
  assign bus.RB_VALID  = rb_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_config_chain_loader.sv
`default_nettype none
// ============================================================================
// tb_config_chain_loader : table, hand-written and random loads against a
//                          bit-queue model of the scan chain.
// Revision : 1.0
// ============================================================================
module tb_config_chain_loader;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 22;
  localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  config_chain_loader_if #(.WORD_W(WORD_W)) bus ();

  config_chain_loader #(
    .WORD_W   (WORD_W),
    .CHAIN_LEN(CHAIN_LEN),
    .CNT_W    (16)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus.slave)
  );

  // Downstream chain: bit 0 is its SOUT, new data enters at the top
  logic [CHAIN_LEN-1:0] chain = 22'h2AAAAA;
  always @(posedge clk) if (bus.CE) chain <= {bus.SOUT, chain[CHAIN_LEN-1:1]};
  assign bus.SIN_RET = chain[0];

  bit                ce_bits[$];
  logic [WORD_W-1:0] rb_words[$];
  int done_cnt = 0, acc_cnt = 0, busy_cnt = 0;

  always @(negedge clk) begin
    if (bus.CE)                          ce_bits.push_back(bus.SOUT);
    if (bus.RB_VALID)                    rb_words.push_back(bus.RB_DATA);
    if (bus.DONE)                        done_cnt++;
    if (bus.DIN_VALID && bus.DIN_READY)  acc_cnt++;
    if (bus.BUSY)                        busy_cnt++;
  end

  int total = 0, bad = 0;
  logic [CHAIN_LEN-1:0] exp_chain = 22'h2AAAAA;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Config bits in shift order, truncated to the chain length
  function automatic logic [CHAIN_LEN-1:0] model_stream(input logic [NW*WORD_W-1:0] words);
    bit q[$];
    logic [CHAIN_LEN-1:0] r;
    for (int i = 0; i < NW * WORD_W; i++) q.push_back(words[i]);
    while (q.size() > CHAIN_LEN) void'(q.pop_back());
    for (int i = 0; i < CHAIN_LEN; i++) r[i] = q[i];
    return r;
  endfunction

  // Readback words are the old chain bits in exit order, zero padded
  function automatic logic [NW*WORD_W-1:0] model_rb(input logic [CHAIN_LEN-1:0] c);
    bit q[$];
    logic [NW*WORD_W-1:0] r;
    for (int i = 0; i < CHAIN_LEN; i++) q.push_back(c[i]);
    while (q.size() < NW * WORD_W) q.push_back(1'b0);
    for (int i = 0; i < NW * WORD_W; i++) r[i] = q[i];
    return r;
  endfunction

  task automatic do_load(input string tag, input logic [NW*WORD_W-1:0] words,
                         input logic [4*NW-1:0] stalls, input bit noisy,
                         input logic [CHAIN_LEN-1:0] exp_stream,
                         input logic [NW*WORD_W-1:0] exp_rb, output int busy_cycles);
    int s_bits, s_rb, d0, a0, b0, guard, stall;
    logic [CHAIN_LEN-1:0] got;
    s_bits = ce_bits.size(); s_rb = rb_words.size();
    d0 = done_cnt; a0 = acc_cnt; b0 = busy_cnt;
    step();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    check({tag, " ready_after_start"}, 32'(bus.DIN_READY), 32'd1);
    for (int k = 0; k < NW; k++) begin
      guard = 0;
      while (!bus.DIN_READY && guard < 40) begin step(); guard++; end
      if (!bus.DIN_READY) begin
        check({tag, " ready_timeout"}, 32'd0, 32'd1);
        break;
      end
      stall = int'(stalls[4*k +: 4]);
      if (stall > 0) begin
        bus.DIN_VALID = 1'b0;
        for (int s = 0; s < stall; s++) begin
          step();
          check({tag, " stall_ce"}, 32'(bus.CE), 32'd0);
        end
      end
      bus.DIN       = words[WORD_W*k +: WORD_W];
      bus.DIN_VALID = 1'b1;
      step();
      if (!noisy) bus.DIN_VALID = 1'b0;
      if (noisy && k == 0) begin
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
      end
    end
    guard = 0;
    while (bus.BUSY && guard < 80) begin step(); guard++; end
    check({tag, " back_to_idle"}, 32'(bus.BUSY), 32'd0);
    bus.DIN_VALID = 1'b0;
    step();
    check({tag, " ce_cycles"}, 32'(ce_bits.size() - s_bits), 32'(CHAIN_LEN));
    for (int i = 0; i < CHAIN_LEN; i++)
      got[i] = (s_bits + i < ce_bits.size()) ? ce_bits[s_bits + i] : 1'bx;
    check({tag, " sout_stream"}, 32'(got), 32'(exp_stream));
    check({tag, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, " accepts"}, 32'(acc_cnt - a0), 32'(NW));
    check({tag, " rb_pulses"}, 32'(rb_words.size() - s_rb), 32'(NW));
    for (int k = 0; k < NW; k++)
      check({tag, " rb_data"},
            (s_rb + k < rb_words.size()) ? 32'(rb_words[s_rb + k]) : 32'hFFFF_FFFF,
            32'(exp_rb[WORD_W*k +: WORD_W]));
    busy_cycles = busy_cnt - b0;
  endtask

  typedef struct packed {
    logic [NW*WORD_W-1:0] words;
    logic [4*NW-1:0]      stalls;
    logic [CHAIN_LEN-1:0] exp_stream;
    logic [NW*WORD_W-1:0] exp_rb;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int bc, cnt, guard, sb;
    logic [NW*WORD_W-1:0] w;
    logic [4*NW-1:0] st;
    bit q[$];

    vecs[0] = '{words: 24'h000000, stalls: 12'h000, exp_stream: 22'h000000, exp_rb: 24'h2AAAAA};
    vecs[1] = '{words: 24'hFF3CA5, stalls: 12'h000, exp_stream: 22'h3F3CA5, exp_rb: 24'h000000};
    vecs[2] = '{words: 24'hFF3CA5, stalls: 12'h050, exp_stream: 22'h3F3CA5, exp_rb: 24'h3F3CA5};
    vecs[3] = '{words: 24'hC13412, stalls: 12'h020, exp_stream: 22'h013412, exp_rb: 24'h3F3CA5};
    vecs[4] = '{words: 24'hFFFFFF, stalls: 12'h310, exp_stream: 22'h3FFFFF, exp_rb: 24'h013412};

    bus.START = 1'b0; bus.DIN = '0; bus.DIN_VALID = 1'b0;

    // START while held in reset must not leave IDLE
    bus.START = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("start_in_reset busy", 32'(bus.BUSY), 32'd0);
    end
    check("start_in_reset ready", 32'(bus.DIN_READY), 32'd0);
    bus.START = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle outputs",
            32'({bus.SOUT, bus.CE, bus.DIN_READY, bus.RB_DATA, bus.RB_VALID, bus.BUSY, bus.DONE}),
            32'd0);
    end

    for (int v = 0; v < 5; v++) begin
      do_load($sformatf("vec%0d", v), vecs[v].words, vecs[v].stalls, 1'b0,
              vecs[v].exp_stream, vecs[v].exp_rb, bc);
      exp_chain = vecs[v].exp_stream;
    end

    // Fastest load with START and DIN_VALID noise during shifting
    w = 24'h96E15A;
    do_load("fast_noisy", w, 12'h000, 1'b1, model_stream(w), model_rb(exp_chain), bc);
    check("fast_noisy busy_cycles", 32'(bc), 32'(NW + CHAIN_LEN + 1));
    exp_chain = model_stream(w);

    for (int r = 0; r < 20; r++) begin
      w  = NW*WORD_W'($urandom);
      st = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      do_load($sformatf("rand%0d", r), w, st, 1'($urandom_range(0, 1)),
              model_stream(w), model_rb(exp_chain), bc);
      exp_chain = model_stream(w);
    end

    // Reset on the 10th CE-high cycle: 9 bits reach the chain before CE drops
    sb = ce_bits.size();
    step();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    bus.DIN = 8'hC3; bus.DIN_VALID = 1'b1;
    cnt = 0; guard = 0;
    while (cnt < 10 && guard < 60) begin
      step(); guard++;
      if (bus.CE) cnt++;
    end
    check("abort ce_count_reached", 32'(cnt), 32'd10);
    rst_n = 1'b0;
    #1;
    check("abort ce_async_drop", 32'(bus.CE), 32'd0);
    check("abort busy", 32'(bus.BUSY), 32'd0);
    bus.DIN_VALID = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("abort bits_shifted", 32'(ce_bits.size() - sb), 32'd9);
    check("abort stays_idle", 32'(bus.BUSY), 32'd0);
    for (int i = 0; i < CHAIN_LEN; i++) q.push_back(exp_chain[i]);
    for (int i = 0; i < 9; i++) begin
      void'(q.pop_front());
      q.push_back(model_stream(24'hC3C3C3)[i]);
    end
    for (int i = 0; i < CHAIN_LEN; i++) exp_chain[i] = q[i];

    w = 24'h0F5AA5;
    do_load("reload", w, 12'h000, 1'b0, model_stream(w), model_rb(exp_chain), bc);
    check("reload chain_contents", 32'(chain), 32'(model_stream(w)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
